// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the wide ALU sequencer and its nibble-step helper.
//   - op-code constants, used both for cmd_op and for the 4-bit ALU select
//   - ALU_SEL_IDLE, the select driven when no pass is in progress
//   - state_e, the sequencer FSM state encoding
//   - op_is_logic(), true for the single-pass-per-nibble bitwise ops
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;

  localparam logic [2:0] ALU_SEL_IDLE = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NOTB,
    ST_ADD,
    ST_INC,
    ST_LOGIC,
    ST_DONE
  } state_e;

  function automatic logic op_is_logic(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/alu_nib_step.sv
// alu_nib_step
// Combinational map from the sequencer's current pass to the 4-bit ALU inputs.
// Ports:
//   state      in   current sequencer state (selects the kind of pass)
//   idx        in   nibble index being processed
//   op         in   latched command op-code
//   a, b       in   latched WORD_W-bit operands
//   part       in   partial nibble from the ADD pass (operand of the INC pass)
//   notb       in   inverted b nibble from the NOTB pass (subtract only)
//   alu_a/b    out  4-bit ALU operands
//   alu_sel    out  ALU op select (ALU_SEL_IDLE outside a pass)
module alu_nib_step
  import alu_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int IDX_W  = 2
) (
  input  state_e            state,
  input  logic [IDX_W-1:0]  idx,
  input  logic [2:0]        op,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [3:0]        part,
  input  logic [3:0]        notb,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  output logic [2:0]        alu_sel
);

  logic [3:0] a_nib;
  logic [3:0] b_nib;

  assign a_nib = a[{idx, 2'b00} +: 4];
  assign b_nib = b[{idx, 2'b00} +: 4];

  // Pick operands per pass type. Subtract reuses the ADD pass with the
  // stored ~b nibble; the INC pass folds the incoming carry in as +1.
  // An invalid op parks in LOGIC for one cycle with the ALU left idle.
  always_comb begin
    alu_a   = 4'd0;
    alu_b   = 4'd0;
    alu_sel = ALU_SEL_IDLE;
    case (state)
      ST_NOTB: begin
        alu_a   = b_nib;
        alu_sel = OP_NOT;
      end
      ST_ADD: begin
        alu_a   = a_nib;
        alu_b   = (op == OP_SUB) ? notb : b_nib;
        alu_sel = OP_ADD;
      end
      ST_INC: begin
        alu_a   = part;
        alu_b   = 4'b0001;
        alu_sel = OP_ADD;
      end
      ST_LOGIC: begin
        if (op_is_logic(op)) begin
          alu_a   = a_nib;
          alu_b   = b_nib;
          alu_sel = op;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_wide_seq.sv
// alu_wide_seq
// Multi-cycle sequencer building WORD_W-bit add/sub/and/or/not out of passes
// through an external combinational 4-bit ALU, one pass per clock.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/ready          command handshake (ready only when idle)
//   cmd_op, cmd_a, cmd_b     op-code and operands
//   rsp_valid/ready          response handshake
//   rsp_y, rsp_carry         result word; carry (add) or borrow (sub)
//   rsp_zero                 result is all zero
//   rsp_ovf                  signed overflow, only when ALU_SEQ_OVF_EN is defined
//   alu_a, alu_b, alu_sel    drive to the 4-bit ALU
//   alu_y, alu_carry, alu_zero  results from the 4-bit ALU
// Build option: define ALU_SEQ_OVF_EN to add the rsp_ovf output.
module alu_wide_seq
  import alu_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [WORD_W-1:0] cmd_a,
  input  logic [WORD_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_y,
  output logic              rsp_carry,
  output logic              rsp_zero,
`ifdef ALU_SEQ_OVF_EN
  output logic              rsp_ovf,
`endif
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  output logic [2:0]        alu_sel,
  input  logic [3:0]        alu_y,
  input  logic              alu_carry,
  input  logic              alu_zero
);

  localparam int NIB   = WORD_W / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [2:0]        op_q, op_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] b_q, b_d;
  logic              cin_q, cin_d;
  logic              zero_q, zero_d;
  logic [WORD_W-1:0] y_q, y_d;
  logic              carry_q, carry_d;
  logic [3:0]        part_q, part_d;
  logic              cadd_q, cadd_d;
  logic [3:0]        notb_q, notb_d;
`ifdef ALU_SEQ_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  logic              nib_fin;
  logic              fin_c;

  alu_nib_step #(
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_step (
    .state   (state_q),
    .idx     (idx_q),
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .part    (part_q),
    .notb    (notb_q),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sel (alu_sel)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_y     = y_q;
  assign rsp_carry = carry_q;
  assign rsp_zero  = zero_q;
`ifdef ALU_SEQ_OVF_EN
  assign rsp_ovf   = ovf_q;
`endif

  // Next-state logic. Each state is one ALU pass; nib_fin marks the final
  // pass of a nibble, where the result nibble, zero flag and carry into the
  // next nibble are committed. The ADD and INC carries can never both be 1,
  // so OR-ing them gives the nibble carry.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    zero_d  = zero_q;
    y_d     = y_q;
    carry_d = carry_q;
    part_d  = part_q;
    cadd_d  = cadd_q;
    notb_d  = notb_q;
`ifdef ALU_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    nib_fin = 1'b0;
    fin_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          a_d     = cmd_a;
          b_d     = cmd_b;
          idx_d   = '0;
          cin_d   = (cmd_op == OP_SUB);
          zero_d  = 1'b1;
          y_d     = '0;
          carry_d = 1'b0;
`ifdef ALU_SEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
          case (cmd_op)
            OP_ADD:  state_d = ST_ADD;
            OP_SUB:  state_d = ST_NOTB;
            default: state_d = ST_LOGIC;
          endcase
        end
      end
      ST_NOTB: begin
        notb_d  = alu_y;
        state_d = ST_ADD;
      end
      ST_ADD: begin
        if (cin_q) begin
          part_d  = alu_y;
          cadd_d  = alu_carry;
          state_d = ST_INC;
        end else begin
          nib_fin = 1'b1;
          fin_c   = alu_carry;
        end
      end
      ST_INC: begin
        nib_fin = 1'b1;
        fin_c   = cadd_q | alu_carry;
      end
      ST_LOGIC: begin
        if (op_is_logic(op_q)) begin
          nib_fin = 1'b1;
        end else begin
          y_d     = '0;
          zero_d  = 1'b1;
          carry_d = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (nib_fin) begin
      y_d[{idx_q, 2'b00} +: 4] = alu_y;
      zero_d = zero_q & alu_zero;
      cin_d  = fin_c;
      if (idx_q == LAST_IDX) begin
        state_d = ST_DONE;
        // Subtract is a + ~b + 1, so a borrow is the absence of carry-out.
        if (op_q == OP_SUB) begin
          carry_d = ~fin_c;
        end else if (op_q == OP_ADD) begin
          carry_d = fin_c;
        end else begin
          carry_d = 1'b0;
        end
`ifdef ALU_SEQ_OVF_EN
        if (op_q == OP_ADD) begin
          ovf_d = (a_q[WORD_W-1] == b_q[WORD_W-1]) && (alu_y[3] != a_q[WORD_W-1]);
        end else if (op_q == OP_SUB) begin
          ovf_d = (a_q[WORD_W-1] != b_q[WORD_W-1]) && (alu_y[3] != a_q[WORD_W-1]);
        end else begin
          ovf_d = 1'b0;
        end
`endif
      end else begin
        idx_d = idx_q + IDX_W'(1);
        case (op_q)
          OP_ADD:  state_d = ST_ADD;
          OP_SUB:  state_d = ST_NOTB;
          default: state_d = ST_LOGIC;
        endcase
      end
    end
  end

  // State register; reset drops any in-flight or pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      zero_q  <= 1'b0;
      y_q     <= '0;
      carry_q <= 1'b0;
      part_q  <= 4'd0;
      cadd_q  <= 1'b0;
      notb_q  <= 4'd0;
`ifdef ALU_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      zero_q  <= zero_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      part_q  <= part_d;
      cadd_q  <= cadd_d;
      notb_q  <= notb_d;
`ifdef ALU_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_wide_seq.sv
// tb_alu_wide_seq
// Testbench for alu_wide_seq with a behavioural model of the 4-bit ALU.
// Expected responses are pushed to a scoreboard queue as each command is
// driven and popped when the response handshake completes.
module tb_alu_wide_seq;

  typedef struct packed {
    logic [15:0] y;
    logic        carry;
    logic        zero;
    logic [7:0]  passes;
  } exp_t;

  typedef struct packed {
    logic [15:0] y;
    logic        carry;
    logic        zero;
    logic        timeout;
    int          lat;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_a = 16'd0;
  logic [15:0] cmd_b = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_y;
  logic        rsp_carry;
  logic        rsp_zero;
`ifdef ALU_SEQ_OVF_EN
  logic        rsp_ovf;
`endif
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [2:0]  alu_sel;
  logic [3:0]  alu_y;
  logic        alu_carry;
  logic        alu_zero;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  alu_wide_seq #(.WORD_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_carry (rsp_carry),
    .rsp_zero  (rsp_zero),
`ifdef ALU_SEQ_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_y     (alu_y),
    .alu_carry (alu_carry),
    .alu_zero  (alu_zero)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit ALU: only add reports a carry.
  always_comb begin
    alu_y     = 4'd0;
    alu_carry = 1'b0;
    case (alu_sel)
      3'b000:  {alu_carry, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  alu_y = alu_a - alu_b;
      3'b010:  alu_y = alu_a & alu_b;
      3'b011:  alu_y = alu_a | alu_b;
      3'b100:  alu_y = ~alu_a;
      default: alu_y = 4'd0;
    endcase
    alu_zero = (alu_y == 4'd0);
  end

  // Reference result and pass count for one command.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic c;
    logic [4:0] s;
    logic [16:0] w;
    logic [3:0] an, bn;
    e = '0;
    c = 1'b0;
    case (op)
      3'b000: begin
        w = {1'b0, a} + {1'b0, b};
        e.y = w[15:0];
        e.carry = w[16];
        for (int n = 0; n < 4; n++) begin
          an = a[n*4 +: 4];
          bn = b[n*4 +: 4];
          e.passes = e.passes + 8'd1 + {7'd0, c};
          s = {1'b0, an} + {1'b0, bn} + {4'd0, c};
          c = s[4];
        end
      end
      3'b001: begin
        e.y = a - b;
        e.carry = (a < b);
        c = 1'b1;
        for (int n = 0; n < 4; n++) begin
          an = a[n*4 +: 4];
          bn = b[n*4 +: 4];
          e.passes = e.passes + 8'd2 + {7'd0, c};
          s = {1'b0, an} + {1'b0, ~bn} + {4'd0, c};
          c = s[4];
        end
      end
      3'b010: begin e.y = a & b; e.passes = 8'd4; end
      3'b011: begin e.y = a | b; e.passes = 8'd4; end
      3'b100: begin e.y = ~a;    e.passes = 8'd4; end
      default: begin e.y = 16'd0; e.passes = 8'd1; end
    endcase
    e.zero = (e.y == 16'd0);
    return e;
  endfunction

  // Drive one command through both handshakes and report what came back.
  task automatic apply_txn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           output obs_t o);
    int n;
    o = '0;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      o.timeout = 1'b1;
      return;
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      o.timeout = 1'b1;
      return;
    end
    o.lat = n;
    o.y = rsp_y;
    o.carry = rsp_carry;
    o.zero = rsp_zero;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_y !== 16'h0000) begin failures++; $display("[TB] FAIL reset_rsp_y got=%h exp=0000", rsp_y); end
    checks++; if (rsp_carry !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_carry got=%b exp=0", rsp_carry); end
    checks++; if (rsp_zero !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_zero got=%b exp=0", rsp_zero); end
    checks++; if (alu_sel !== 3'b111) begin failures++; $display("[TB] FAIL reset_alu_sel got=%b exp=111", alu_sel); end
    checks++; if ({alu_a, alu_b} !== 8'h00) begin failures++; $display("[TB] FAIL reset_alu_ab got=%h exp=00", {alu_a, alu_b}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [2:0]  d_op [9];
    logic [15:0] d_a  [9];
    logic [15:0] d_b  [9];
    logic [15:0] d_y  [9];
    logic        d_c  [9];
    logic        d_z  [9];
    logic [7:0]  d_p  [9];
    exp_t e;
    obs_t o;
    d_op = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    d_a  = '{16'h0001, 16'h00FF, 16'hFFFF, 16'h0005, 16'h0000, 16'hF0F0, 16'hF0F0, 16'h1234, 16'h5A5A};
    d_b  = '{16'h0002, 16'h0001, 16'h0001, 16'h0003, 16'h0001, 16'h0FF0, 16'h0FF0, 16'hAAAA, 16'h1111};
    d_y  = '{16'h0003, 16'h0100, 16'h0000, 16'h0002, 16'hFFFF, 16'h00F0, 16'hFFF0, 16'hEDCB, 16'h0000};
    d_c  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    d_z  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    d_p  = '{8'd4, 8'd6, 8'd7, 8'd12, 8'd9, 8'd4, 8'd4, 8'd4, 8'd1};
    for (int i = 0; i < 9; i++) begin
      e.y = d_y[i]; e.carry = d_c[i]; e.zero = d_z[i]; e.passes = d_p[i];
      sb.push_back(e);
      apply_txn(d_op[i], d_a[i], d_b[i], o);
      e = sb.pop_front();
      checks++;
      if (o.timeout) begin
        failures++; $display("[TB] FAIL dir%0d_timeout got=no_response exp=response", i);
      end else begin
        checks++; if (o.y !== e.y) begin failures++; $display("[TB] FAIL dir%0d_y got=%h exp=%h", i, o.y, e.y); end
        checks++; if (o.carry !== e.carry) begin failures++; $display("[TB] FAIL dir%0d_carry got=%b exp=%b", i, o.carry, e.carry); end
        checks++; if (o.zero !== e.zero) begin failures++; $display("[TB] FAIL dir%0d_zero got=%b exp=%b", i, o.zero, e.zero); end
        checks++; if (o.lat !== int'(e.passes)) begin failures++; $display("[TB] FAIL dir%0d_latency got=%0d exp=%0d", i, o.lat, e.passes); end
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [15:0] a, b;
    exp_t e;
    obs_t o;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 5));
      if (op == 3'd5) op = 3'd6;
      a = 16'($urandom);
      b = 16'($urandom);
      sb.push_back(model(op, a, b));
      apply_txn(op, a, b, o);
      e = sb.pop_front();
      checks++;
      if (o.timeout) begin
        failures++; $display("[TB] FAIL rnd%0d_timeout got=no_response exp=response", i);
      end else begin
        checks++; if (o.y !== e.y) begin failures++; $display("[TB] FAIL rnd%0d_y op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, o.y, e.y); end
        checks++; if (o.carry !== e.carry) begin failures++; $display("[TB] FAIL rnd%0d_carry got=%b exp=%b", i, o.carry, e.carry); end
        checks++; if (o.zero !== e.zero) begin failures++; $display("[TB] FAIL rnd%0d_zero got=%b exp=%b", i, o.zero, e.zero); end
        checks++; if (o.lat !== int'(e.passes)) begin failures++; $display("[TB] FAIL rnd%0d_latency got=%0d exp=%0d", i, o.lat, e.passes); end
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    obs_t o;
    int n;
    sb.push_back(model(3'd0, 16'h1234, 16'h1111));
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 16'h1234; cmd_b = 16'h1111;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    checks++;
    if (!rsp_valid) begin
      failures++; $display("[TB] FAIL bp_timeout got=no_response exp=response");
    end else begin
      // Offer a second command while the response is stalled.
      cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = 16'h0000; cmd_b = 16'h0001;
      for (int k = 0; k < 5; k++) begin
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp%0d_rsp_valid got=%b exp=1", k, rsp_valid); end
        checks++; if (rsp_y !== e.y) begin failures++; $display("[TB] FAIL bp%0d_y got=%h exp=%h", k, rsp_y, e.y); end
        checks++; if ({rsp_carry, rsp_zero} !== {e.carry, e.zero}) begin failures++; $display("[TB] FAIL bp%0d_flags got=%b exp=%b", k, {rsp_carry, rsp_zero}, {e.carry, e.zero}); end
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp%0d_cmd_ready got=%b exp=0", k, cmd_ready); end
        @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_after_cmd_ready got=%b exp=1", cmd_ready); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_after_rsp_valid got=%b exp=0", rsp_valid); end
    end
    sb.push_back(model(3'd1, 16'h0000, 16'h0001));
    apply_txn(3'd1, 16'h0000, 16'h0001, o);
    e = sb.pop_front();
    checks++;
    if (o.timeout) begin
      failures++; $display("[TB] FAIL bp2_timeout got=no_response exp=response");
    end else begin
      checks++; if (o.y !== e.y) begin failures++; $display("[TB] FAIL bp2_y got=%h exp=%h", o.y, e.y); end
      checks++; if (o.lat !== int'(e.passes)) begin failures++; $display("[TB] FAIL bp2_latency got=%0d exp=%0d", o.lat, e.passes); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    obs_t o;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = 16'h0005; cmd_b = 16'h0003;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (alu_sel !== 3'b111) begin failures++; $display("[TB] FAIL rstmid_alu_sel got=%b exp=111", alu_sel); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_after_rsp_valid got=%b exp=0", rsp_valid); end
    sb.push_back(model(3'd0, 16'h00FF, 16'h0001));
    apply_txn(3'd0, 16'h00FF, 16'h0001, o);
    e = sb.pop_front();
    checks++;
    if (o.timeout) begin
      failures++; $display("[TB] FAIL rstmid_add_timeout got=no_response exp=response");
    end else begin
      checks++; if (o.y !== e.y) begin failures++; $display("[TB] FAIL rstmid_add_y got=%h exp=%h", o.y, e.y); end
      checks++; if (o.lat !== int'(e.passes)) begin failures++; $display("[TB] FAIL rstmid_add_latency got=%0d exp=%0d", o.lat, e.passes); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=running exp=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
